cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  upstream op present.
REQ-005 in_ready  output  1  module can accept an op this cycle.
REQ-006 cond  input  4  condition code of the op.
REQ-007 alu_result  input  5  ALU result of the op.
REQ-008 alu_flags  input  4  ALU flags {N,Z,C,V}, bit3 = N.
REQ-009 flag_write  input  2  bit1 enables N,Z update; bit0 enables C,V update.
REQ-010 reg_write_in  input  1  op requests a register write.
REQ-011 out_valid  output  1  output register holds an op.
REQ-012 out_ready  input  1  downstream accepts the output.
REQ-013 out_result  output  5  registered alu_result.
REQ-014 out_reg_write  output  1  reg_write_in gated by cond_ex.
REQ-015 out_cond_ex  output  1  registered condition outcome.
REQ-016 flags  output  4  architectural flag register {N,Z,C,V}.
REQ-017 exec_cnt, skip_cnt  output  8 each  saturating counts of executed and skipped ops.

Function
REQ-018 in_ready SHALL equal rst_n & (~out_valid | out_ready).
REQ-019 An op is accepted in a cycle where in_valid & in_ready are both 1; no other input is sampled.
REQ-020 cond_ex SHALL be evaluated combinationally against the current flags register, not alu_flags.
REQ-021 Codes: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V; 12 GT ~Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-022 On acceptance, the output register SHALL load out_result=alu_result, out_cond_ex=cond_ex, out_reg_write=reg_write_in&cond_ex, and out_valid SHALL become 1 on the next cycle; latency is 1 cycle.
REQ-023 On acceptance with cond_ex=1, flags[3:2] SHALL load alu_flags[3:2] if flag_write[1], and flags[1:0] SHALL load alu_flags[1:0] if flag_write[0]; the unselected bits hold.
REQ-024 On acceptance with cond_ex=0, flags SHALL hold.
REQ-025 Back-to-back accepted ops: the second op SHALL evaluate its condition against the flags written by the first.
REQ-026 If out_valid & out_ready and no acceptance occurs, out_valid SHALL clear next cycle; out_result, out_cond_ex and out_reg_write hold their values.
REQ-027 If out_valid & ~out_ready, all output-register fields and flags SHALL hold, and in_ready is 0.
REQ-028 Simultaneous drain and accept SHALL replace the output register with the new op, and out_valid stays 1.
REQ-029 exec_cnt SHALL increment on each acceptance with cond_ex=1, and skip_cnt on each acceptance with cond_ex=0.
REQ-030 Both counters SHALL saturate at 255 and never wrap.

Reset
REQ-031 With rst_n=0 at a rising edge: flags=0000, out_valid=0, out_result=0, out_cond_ex=0, out_reg_write=0, exec_cnt=0, skip_cnt=0.
REQ-032 in_ready SHALL be 0 while rst_n=0; an op presented during reset SHALL be dropped and SHALL have no effect on flags or counters.
REQ-033 Reset asserted while out_valid=1 and stalled SHALL discard the held op.

Structure
REQ-034 A shared package SHALL hold the 4-bit condition-code constants (EQ..NV) and the flag bit indices (N=3, Z=2, C=1, V=0).
REQ-035 Condition evaluation SHALL be one combinational sub-module, cond_check (inputs cond and flags; output cond_ex); all registers live in cond_unit.

Verification
REQ-036 Reset, then accept an op with cond=14, alu_flags=0100, flag_write=11, result=00000 -> next cycle flags=0100, out_valid=1, out_cond_ex=1, exec_cnt=1.
REQ-037 With flags=0100, an op with cond=1 (NE), reg_write_in=1, flag_write=11, alu_flags=1000 -> out_reg_write=0, flags stay 0100, skip_cnt increments.
REQ-038 Back-to-back ops: first AL with alu_flags=0010, flag_write=01; second cond=2 (CS) -> second op out_cond_ex=1; flags=0010 (N,Z unchanged from 00).
REQ-039 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and out_result and flags are stable; release -> drain and accept occur in the same cycle, and out_valid stays 1.
REQ-040 Run 300 accepted ops with cond=15 -> skip_cnt=255, exec_cnt=0, flags unchanged.
REQ-041 Assert rst_n=0 for one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, flags=0000, counters=0.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// Shared constants and types for the conditional-execution unit: condition codes,
// flag bit positions and the output-register layout.
package cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef struct packed {
        logic [4:0] result;
        logic       cond_ex;
        logic       reg_write;
    } out_reg_t;

endpackage

// File: rtl/cond_unit_if.sv
// Op-in / result-out handshake bundle for cond_unit; master drives ops, slave is the unit.
interface cond_unit_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cond;
    logic [4:0] alu_result;
    logic [3:0] alu_flags;
    logic [1:0] flag_write;
    logic       reg_write_in;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_result;
    logic       out_reg_write;
    logic       out_cond_ex;
    logic [3:0] flags;
    logic [7:0] exec_cnt;
    logic [7:0] skip_cnt;

    modport master (
        output in_valid, cond, alu_result, alu_flags, flag_write, reg_write_in, out_ready,
        input  in_ready, out_valid, out_result, out_reg_write, out_cond_ex, flags,
               exec_cnt, skip_cnt
    );

    modport slave (
        input  in_valid, cond, alu_result, alu_flags, flag_write, reg_write_in, out_ready,
        output in_ready, out_valid, out_result, out_reg_write, out_cond_ex, flags,
               exec_cnt, skip_cnt
    );
endinterface

// File: rtl/cond_unit_cond_check.sv
// Condition-code evaluator against a {N,Z,C,V} flag word.
// Latency: purely combinational. Backpressure: none.
// Holds no state; the caller decides which flag word is architectural.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: gates register/flag writes by cond against the flag register.
// Latency: 1 cycle from acceptance to out_valid.
// Backpressure: single output register; in_ready drops while it is full and out_ready is low.
module cond_unit
    import cond_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    cond_unit_if.slave  bus
);
    out_reg_t   out_q;
    logic       out_vld_q;
    logic [3:0] flags_q;
    logic [7:0] exec_cnt_q;
    logic [7:0] skip_cnt_q;
    logic       cond_ex;
    logic       accept;

    // Condition sees the registered flags, so back-to-back ops chain through flags_q.
    cond_check u_cond_check (
        .cond    (bus.cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign bus.in_ready = rst_n & (~out_vld_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            flags_q    <= 4'b0000;
            exec_cnt_q <= 8'd0;
            skip_cnt_q <= 8'd0;
        end else if (accept) begin
            out_q.result    <= bus.alu_result;
            out_q.cond_ex   <= cond_ex;
            out_q.reg_write <= bus.reg_write_in & cond_ex;
            out_vld_q       <= 1'b1;
            if (cond_ex) begin
                if (bus.flag_write[1]) begin
                    flags_q[FLAG_N] <= bus.alu_flags[FLAG_N];
                    flags_q[FLAG_Z] <= bus.alu_flags[FLAG_Z];
                end
                if (bus.flag_write[0]) begin
                    flags_q[FLAG_C] <= bus.alu_flags[FLAG_C];
                    flags_q[FLAG_V] <= bus.alu_flags[FLAG_V];
                end
                if (exec_cnt_q != CNT_MAX) exec_cnt_q <= exec_cnt_q + 8'd1;
            end else begin
                if (skip_cnt_q != CNT_MAX) skip_cnt_q <= skip_cnt_q + 8'd1;
            end
        end else if (out_vld_q && bus.out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.out_valid     = out_vld_q;
    assign bus.out_result    = out_q.result;
    assign bus.out_cond_ex   = out_q.cond_ex;
    assign bus.out_reg_write = out_q.reg_write;
    assign bus.flags         = flags_q;
    assign bus.exec_cnt      = exec_cnt_q;
    assign bus.skip_cnt      = skip_cnt_q;
endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of flags, output register and counters.
module tb_cond_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    cond_unit_if bus ();

    cond_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    bit       m_vld;
    bit [4:0] m_res;
    bit       m_ce;
    bit       m_rw;
    bit       m_n, m_z, m_c, m_v;
    int       m_exec, m_skip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_cond(input int code);
        case (code)
            0:  return m_z;
            1:  return !m_z;
            2:  return m_c;
            3:  return !m_c;
            4:  return m_n;
            5:  return !m_n;
            6:  return m_v;
            7:  return !m_v;
            8:  return m_c && !m_z;
            9:  return !m_c || m_z;
            10: return m_n == m_v;
            11: return m_n != m_v;
            12: return !m_z && (m_n == m_v);
            13: return m_z || (m_n != m_v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_flags();
        return {m_n, m_z, m_c, m_v};
    endfunction

    // One clock: check in_ready against the model, advance the model, check all outputs.
    task automatic step();
        bit ready, ce;
        #1;
        ready = rst_n && (!m_vld || bus.out_ready);
        check("in_ready", bus.in_ready, ready);
        if (!rst_n) begin
            m_vld = 0; m_res = 0; m_ce = 0; m_rw = 0;
            {m_n, m_z, m_c, m_v} = 4'b0;
            m_exec = 0; m_skip = 0;
        end else if (bus.in_valid && ready) begin
            ce    = model_cond(int'(bus.cond));
            m_vld = 1;
            m_res = bus.alu_result;
            m_ce  = ce;
            m_rw  = bus.reg_write_in && ce;
            if (ce) begin
                if (bus.flag_write[1]) begin m_n = bus.alu_flags[3]; m_z = bus.alu_flags[2]; end
                if (bus.flag_write[0]) begin m_c = bus.alu_flags[1]; m_v = bus.alu_flags[0]; end
                if (m_exec < 255) m_exec++;
            end else if (m_skip < 255) begin
                m_skip++;
            end
        end else if (m_vld && bus.out_ready) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", bus.out_valid, m_vld);
        check("out_result", bus.out_result, m_res);
        check("out_cond_ex", bus.out_cond_ex, m_ce);
        check("out_reg_write", bus.out_reg_write, m_rw);
        check("flags", bus.flags, model_flags());
        check("exec_cnt", bus.exec_cnt, m_exec);
        check("skip_cnt", bus.skip_cnt, m_skip);
    endtask

    task automatic drive(input bit vld, input logic [3:0] cnd, input logic [4:0] res,
                         input logic [3:0] af, input logic [1:0] fw, input bit rw, input bit ordy);
        bus.in_valid     = vld;
        bus.cond         = cnd;
        bus.alu_result   = res;
        bus.alu_flags    = af;
        bus.flag_write   = fw;
        bus.reg_write_in = rw;
        bus.out_ready    = ordy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [4:0] held_res;
    logic [3:0] held_flags;

    initial begin
        m_vld = 0; m_res = 0; m_ce = 0; m_rw = 0;
        {m_n, m_z, m_c, m_v} = 4'b0; m_exec = 0; m_skip = 0;
        rst_n = 1'b0;
        // op presented during reset must be dropped
        drive(1, 4'd14, 5'h1F, 4'hF, 2'b11, 1, 1);
        @(negedge clk);
        step();
        check("rst_flags", bus.flags, 4'b0000);
        check("rst_vld", bus.out_valid, 1'b0);
        check("rst_exec", bus.exec_cnt, 8'd0);
        rst_n = 1'b1;

        // AL op writes all flags
        drive(1, 4'd14, 5'd0, 4'b0100, 2'b11, 0, 1);
        step();
        check("al_flags", bus.flags, 4'b0100);
        check("al_vld", bus.out_valid, 1'b1);
        check("al_ce", bus.out_cond_ex, 1'b1);
        check("al_exec", bus.exec_cnt, 8'd1);

        // NE with Z=1 is skipped
        drive(1, 4'd1, 5'd7, 4'b1000, 2'b11, 1, 1);
        step();
        check("ne_rw", bus.out_reg_write, 1'b0);
        check("ne_flags", bus.flags, 4'b0100);
        check("ne_skip", bus.skip_cnt, 8'd1);

        // back-to-back: second op sees flags from the first
        do_reset();
        drive(1, 4'd14, 5'd3, 4'b0010, 2'b01, 1, 1);
        step();
        drive(1, 4'd2, 5'd4, 4'b1111, 2'b00, 1, 1);
        step();
        check("b2b_ce", bus.out_cond_ex, 1'b1);
        check("b2b_flags", bus.flags, 4'b0010);

        // stall with a full output register
        drive(1, 4'd14, 5'd9, 4'b1001, 2'b11, 1, 0);
        step();
        held_res   = bus.out_result;
        held_flags = bus.flags;
        drive(1, 4'd14, 5'd21, 4'b0110, 2'b11, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_rdy", bus.in_ready, 1'b0);
            check("stall_res", bus.out_result, held_res);
            check("stall_flags", bus.flags, held_flags);
        end
        bus.out_ready = 1'b1;
        step();
        check("release_vld", bus.out_valid, 1'b1);
        check("release_res", bus.out_result, 5'd21);

        // NV saturation of skip_cnt
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1, 4'd15, 5'($urandom), 4'($urandom), 2'b11, 1, 1);
            step();
        end
        check("sat_skip", bus.skip_cnt, 8'd255);
        check("sat_exec", bus.exec_cnt, 8'd0);
        check("sat_flags", bus.flags, 4'b0000);

        // reset while stalled discards the held op
        drive(1, 4'd14, 5'd5, 4'b1111, 2'b11, 1, 0);
        step();
        step();
        do_reset();
        check("rst_stall_vld", bus.out_valid, 1'b0);
        check("rst_stall_flags", bus.flags, 4'b0000);
        check("rst_stall_skip", bus.skip_cnt, 8'd0);

        // random traffic including occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            drive(bit'($urandom_range(0, 3) != 0), 4'($urandom), 5'($urandom), 4'($urandom),
                  2'($urandom), bit'($urandom), bit'($urandom_range(0, 3) != 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
